stencil_iter_ctrl: RTL and testbench

STENCIL_ITER_CTRL -- requirements
Module: stencil_iter_ctrl

---
 rtl/stencil_iter_ctrl_pkg.sv | 15 +
 rtl/stencil_iter_cnt.sv | 38 +++
 rtl/stencil_iter_ctrl.sv | 151 +++++++++++++++
 tb/tb_stencil_iter_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stencil_iter_ctrl_pkg.sv
// Shared constants for the stencil iteration controller: FSM state encoding
// and the default iteration counter width.
package stencil_iter_ctrl_pkg;

   localparam int unsigned IterWDefault = 16;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StLaunch  = 3'd1,
      StWaitLow = 3'd2,
      StRun     = 3'd3,
      StSwap    = 3'd4
   } state_e;

endpackage

// File: rtl/stencil_iter_cnt.sv
// Sweep counter with latched target count and terminal compare.
// o_last flags that the sweep now being retired is the final one.
module stencil_iter_cnt #(
   parameter int unsigned ITER_W = 16
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              i_load,
   input  logic [ITER_W-1:0] i_iters,
   input  logic              i_inc,
   output logic [ITER_W-1:0] o_count,
   output logic              o_last
);

   logic [ITER_W-1:0] r_count;
   logic [ITER_W-1:0] r_iters;
   logic [ITER_W-1:0] w_count_inc;

   assign w_count_inc = r_count + ITER_W'(1);

   // Load clears the count and captures the target; inc retires one sweep.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_count <= '0;
         r_iters <= '0;
      end else if (i_load) begin
         r_count <= '0;
         r_iters <= i_iters;
      end else if (i_inc) begin
         r_count <= w_count_inc;
      end
   end

   // Equality compare only: the target never exceeds 2^ITER_W-1, so no wrap.
   assign o_count = r_count;
   assign o_last  = (w_count_inc == r_iters);

endmodule

// File: rtl/stencil_iter_ctrl.sv
// Iteration controller for the stencil coprocessor: launches one sweep per
// iteration, ping-pongs the source/destination buffers between sweeps and
// reports the buffer holding the final result.
module stencil_iter_ctrl
   import stencil_iter_ctrl_pkg::*;
#(
   parameter int unsigned ITER_W = IterWDefault
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              START,
   input  logic              ABORT,
   input  logic [15:0]       SIZE,
   input  logic [31:0]       BUF_A,
   input  logic [31:0]       BUF_B,
   input  logic [ITER_W-1:0] ITERS,
   output logic              CORE_GO,
   output logic [15:0]       CORE_SIZE,
   output logic [31:0]       CORE_SRC,
   output logic [31:0]       CORE_DST,
   input  logic              CORE_DONE,
   input  logic              FIFO_BUSY,
   output logic              BUSY,
   output logic              DONE,
   output logic              ABORTED,
   output logic [ITER_W-1:0] ITER_NOW,
   output logic [31:0]       RESULT_ADDR
);

   state_e      r_state;
   state_e      w_state_d;
   logic        r_go;
   logic [15:0] r_size;
   logic [31:0] r_src;
   logic [31:0] r_dst;
   logic [31:0] r_result;
   logic        r_done;
   logic        r_aborted;
   logic        r_abort_pend;

   logic        w_accept;
   logic        w_iters_zero;
   logic        w_swap;
   logic        w_last;
   logic        w_finish;

   assign w_accept     = START && (r_state == StIdle);
   assign w_iters_zero = (ITERS == '0);
   assign w_swap       = (r_state == StSwap);
   assign w_finish     = w_swap && (w_last || r_abort_pend);

   stencil_iter_cnt #(
      .ITER_W (ITER_W)
   ) u_cnt (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .i_load  (w_accept),
      .i_iters (ITERS),
      .i_inc   (w_swap),
      .o_count (ITER_NOW),
      .o_last  (w_last)
   );

   // FSM state register.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state logic; a zero-iteration start completes without leaving idle.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
            if (START && !w_iters_zero) w_state_d = StLaunch;
         end
         StLaunch:  w_state_d = StWaitLow;
         StWaitLow: begin
            if (!CORE_DONE) w_state_d = StRun;
         end
         StRun: begin
            // Data mover must drain before the sweep counts as complete.
            if (CORE_DONE && !FIFO_BUSY) w_state_d = StSwap;
         end
         StSwap:    w_state_d = w_finish ? StIdle : StLaunch;
         default:   w_state_d = StIdle;
      endcase
   end

   // Registered go pulse, raised in the cycle after LAUNCH.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_go <= 1'b0;
      end else begin
         r_go <= (r_state == StLaunch);
      end
   end

   // Abort request is remembered until the in-flight sweep retires.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_abort_pend <= 1'b0;
      end else if (w_accept) begin
         r_abort_pend <= ABORT && !w_iters_zero;
      end else if (w_finish) begin
         r_abort_pend <= 1'b0;
      end else if (ABORT && (r_state != StIdle)) begin
         r_abort_pend <= 1'b1;
      end
   end

   // Job parameters, buffer ping-pong and completion status.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_size    <= '0;
         r_src     <= '0;
         r_dst     <= '0;
         r_result  <= '0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
      end else if (w_accept) begin
         r_size    <= SIZE;
         r_src     <= BUF_A;
         r_dst     <= BUF_B;
         r_done    <= w_iters_zero;
         r_aborted <= 1'b0;
         if (w_iters_zero) r_result <= BUF_A;
      end else if (w_swap) begin
         r_src <= r_dst;
         r_dst <= r_src;
         if (w_finish) begin
            r_done    <= 1'b1;
            r_aborted <= r_abort_pend;
            r_result  <= r_dst;
         end
      end
   end

   assign CORE_GO     = r_go;
   assign CORE_SIZE   = r_size;
   assign CORE_SRC    = r_src;
   assign CORE_DST    = r_dst;
   assign BUSY        = (r_state != StIdle);
   assign DONE        = r_done;
   assign ABORTED     = r_aborted;
   assign RESULT_ADDR = r_result;

endmodule

// File: tb/tb_stencil_iter_ctrl.sv
// Self-checking bench for stencil_iter_ctrl with a behavioural coprocessor
// model. ITER_W is 4 so the maximum-count case runs in reasonable time.
module tb_stencil_iter_ctrl;

   localparam int unsigned ITER_W = 4;

   logic              ACLK = 1'b0;
   logic              ARESETN = 1'b1;
   logic              START = 1'b0;
   logic              ABORT = 1'b0;
   logic [15:0]       SIZE = '0;
   logic [31:0]       BUF_A = '0;
   logic [31:0]       BUF_B = '0;
   logic [ITER_W-1:0] ITERS = '0;
   logic              CORE_GO;
   logic [15:0]       CORE_SIZE;
   logic [31:0]       CORE_SRC;
   logic [31:0]       CORE_DST;
   logic              CORE_DONE;
   logic              FIFO_BUSY = 1'b0;
   logic              BUSY;
   logic              DONE;
   logic              ABORTED;
   logic [ITER_W-1:0] ITER_NOW;
   logic [31:0]       RESULT_ADDR;

   int n_chk = 0;
   int n_fail = 0;

   stencil_iter_ctrl #(
      .ITER_W (ITER_W)
   ) dut (
      .ACLK        (ACLK),
      .ARESETN     (ARESETN),
      .START       (START),
      .ABORT       (ABORT),
      .SIZE        (SIZE),
      .BUF_A       (BUF_A),
      .BUF_B       (BUF_B),
      .ITERS       (ITERS),
      .CORE_GO     (CORE_GO),
      .CORE_SIZE   (CORE_SIZE),
      .CORE_SRC    (CORE_SRC),
      .CORE_DST    (CORE_DST),
      .CORE_DONE   (CORE_DONE),
      .FIFO_BUSY   (FIFO_BUSY),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .ABORTED     (ABORTED),
      .ITER_NOW    (ITER_NOW),
      .RESULT_ADDR (RESULT_ADDR)
   );

   always #5 ACLK = ~ACLK;

   // Coprocessor model: drops CORE_DONE on a go pulse, raises it sweep_len
   // cycles later; logs the job parameters seen with every go pulse.
   int          sweep_len = 6;
   int          cp_cnt;
   int          go_n = 0;
   logic [31:0] go_src [64];
   logic [31:0] go_dst [64];
   logic        core_done;

   assign CORE_DONE = core_done;

   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         core_done <= 1'b1;
         cp_cnt    <= 0;
      end else if (CORE_GO) begin
         core_done          <= 1'b0;
         cp_cnt             <= sweep_len;
         go_src[go_n % 64]  <= CORE_SRC;
         go_dst[go_n % 64]  <= CORE_DST;
         go_n               <= go_n + 1;
      end else if (!core_done) begin
         if (cp_cnt <= 1) core_done <= 1'b1;
         else             cp_cnt    <= cp_cnt - 1;
      end
   end

   typedef struct {
      int unsigned iters;
      logic [31:0] a;
      logic [31:0] b;
      int          abort_sw;   // 0 none, -1 with START, k>0 during sweep k
      bit          pre_abort;  // ABORT pulse while idle before the job
      int          len;
      int          exp_gos;
      int unsigned exp_now;
      logic [31:0] exp_res;
      bit          exp_ab;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic wait_done();
      int cyc = 0;
      while (!DONE && cyc < 20000) begin
         step();
         cyc++;
      end
      check("wait_done_timeout", DONE, 1'b1);
   endtask

   task automatic run_job(input vec_t v, input logic [15:0] sz);
      int base;
      int cyc;
      int gos;
      bit sent;
      bit excl_ok;
      bit log_ok;
      sweep_len = v.len;
      if (v.pre_abort) begin
         ABORT = 1'b1;
         step();
         ABORT = 1'b0;
         check("idle_abort_busy", BUSY, 1'b0);
      end
      base  = go_n;
      ITERS = ITER_W'(v.iters);
      BUF_A = v.a;
      BUF_B = v.b;
      SIZE  = sz;
      START = 1'b1;
      ABORT = (v.abort_sw < 0);
      step();
      START = 1'b0;
      ABORT = 1'b0;
      check("start_clears_done", DONE, 1'b0);
      check("start_sets_busy", BUSY, 1'b1);
      excl_ok = 1'b1;
      sent    = 1'b0;
      cyc     = 0;
      while (!DONE && cyc < 20000) begin
         step();
         cyc++;
         if (BUSY && DONE) excl_ok = 1'b0;
         ABORT = 1'b0;
         if (v.abort_sw > 0 && !sent && (go_n - base) == v.abort_sw && !CORE_DONE) begin
            ABORT = 1'b1;
            sent  = 1'b1;
         end
      end
      ABORT = 1'b0;
      check("job_done", DONE, 1'b1);
      gos = go_n - base;
      check("go_count", gos, v.exp_gos);
      check("iter_now", ITER_NOW, v.exp_now);
      check("result_addr", RESULT_ADDR, v.exp_res);
      check("aborted", ABORTED, v.exp_ab);
      check("busy_after_done", BUSY, 1'b0);
      check("core_size", CORE_SIZE, sz);
      check("busy_done_exclusive", excl_ok, 1'b1);
      log_ok = 1'b1;
      for (int j = 0; j < gos && j < 64; j++) begin
         if (go_src[(base + j) % 64] !== ((j % 2 == 0) ? v.a : v.b)) log_ok = 1'b0;
         if (go_dst[(base + j) % 64] !== ((j % 2 == 0) ? v.b : v.a)) log_ok = 1'b0;
      end
      check("pingpong_src_dst", log_ok, 1'b1);
      // Status must hold while idle.
      repeat (3) step();
      check("done_holds", {DONE, RESULT_ADDR}, {1'b1, v.exp_res});
   endtask

   initial begin : main
      int base;
      bit ok;
      vec_t rv;

      vecs[0] = '{iters: 3,  a: 32'h1000, b: 32'h2000, abort_sw: 0,  pre_abort: 0, len: 20,
                  exp_gos: 3,  exp_now: 3,  exp_res: 32'h2000, exp_ab: 0};
      vecs[1] = '{iters: 4,  a: 32'h1000, b: 32'h2000, abort_sw: 2,  pre_abort: 0, len: 8,
                  exp_gos: 2,  exp_now: 2,  exp_res: 32'h1000, exp_ab: 1};
      vecs[2] = '{iters: 15, a: 32'h1000, b: 32'h2000, abort_sw: 0,  pre_abort: 0, len: 5,
                  exp_gos: 15, exp_now: 15, exp_res: 32'h2000, exp_ab: 0};
      vecs[3] = '{iters: 2,  a: 32'h00A0, b: 32'h00B0, abort_sw: 0,  pre_abort: 1, len: 4,
                  exp_gos: 2,  exp_now: 2,  exp_res: 32'h00A0, exp_ab: 0};
      vecs[4] = '{iters: 1,  a: 32'h0100, b: 32'h0200, abort_sw: 1,  pre_abort: 0, len: 6,
                  exp_gos: 1,  exp_now: 1,  exp_res: 32'h0200, exp_ab: 1};
      vecs[5] = '{iters: 4,  a: 32'h0300, b: 32'h0400, abort_sw: -1, pre_abort: 0, len: 6,
                  exp_gos: 1,  exp_now: 1,  exp_res: 32'h0400, exp_ab: 1};

      // Reset values.
      #2 ARESETN = 1'b0;
      #1;
      check("reset_outputs",
            {CORE_GO, BUSY, DONE, ABORTED, ITER_NOW, RESULT_ADDR, CORE_SRC, CORE_DST, CORE_SIZE},
            '0);
      repeat (2) step();
      ARESETN = 1'b1;
      step();

      // Zero-iteration start: completes without ever going busy.
      base  = go_n;
      ITERS = '0;
      BUF_A = 32'h1000;
      BUF_B = 32'h2000;
      START = 1'b1;
      step();
      START = 1'b0;
      check("zero_busy_c1", BUSY, 1'b0);
      step();
      check("zero_busy_c2", BUSY, 1'b0);
      check("zero_done", DONE, 1'b1);
      check("zero_result", RESULT_ADDR, 32'h1000);
      repeat (4) step();
      check("zero_no_go", go_n - base, 0);

      // START to CORE_GO latency, and one-cycle go pulse.
      sweep_len = 6;
      ITERS = ITER_W'(1);
      START = 1'b1;
      step();
      START = 1'b0;
      check("lat_go_c1", CORE_GO, 1'b0);
      step();
      check("lat_go_c2", CORE_GO, 1'b1);
      step();
      check("lat_go_c3", CORE_GO, 1'b0);
      wait_done();

      // Table-driven jobs.
      for (int i = 0; i < 6; i++) begin
         run_job(vecs[i], 16'h0040 + 16'(i));
      end

      // Sweep completion held off by a busy data mover; mid-job START ignored.
      sweep_len = 4;
      FIFO_BUSY = 1'b1;
      base  = go_n;
      ITERS = ITER_W'(1);
      BUF_A = 32'h3000;
      BUF_B = 32'h4000;
      START = 1'b1;
      step();
      START = 1'b0;
      for (int c = 0; c < 200 && !(go_n > base && CORE_DONE); c++) step();
      check("fifo_core_done_seen", CORE_DONE, 1'b1);
      ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         START = (c == 3);
         BUF_A = (c == 3) ? 32'h5000 : 32'h3000;
         step();
         if (!BUSY || DONE || ITER_NOW != '0) ok = 1'b0;
      end
      START = 1'b0;
      BUF_A = 32'h3000;
      check("fifo_holds_swap", ok, 1'b1);
      FIFO_BUSY = 1'b0;
      step();
      check("fifo_done_c1", DONE, 1'b0);
      step();
      check("fifo_done_c2", DONE, 1'b1);
      check("fifo_iter_now", ITER_NOW, 1);
      check("fifo_result", RESULT_ADDR, 32'h4000);
      check("fifo_go_count", go_n - base, 1);

      // Reset in RUN with an abort pending, then a fresh full job.
      sweep_len = 6;
      base  = go_n;
      ITERS = ITER_W'(5);
      BUF_A = 32'h1000;
      BUF_B = 32'h2000;
      START = 1'b1;
      step();
      START = 1'b0;
      for (int c = 0; c < 200 && !((go_n - base) == 1 && !CORE_DONE); c++) step();
      ABORT = 1'b1;
      step();
      ABORT = 1'b0;
      step();
      ARESETN = 1'b0;
      #1;
      check("midjob_reset_outputs",
            {CORE_GO, BUSY, DONE, ABORTED, ITER_NOW, RESULT_ADDR, CORE_SRC, CORE_DST, CORE_SIZE},
            '0);
      step();
      ARESETN = 1'b1;
      repeat (4) step();
      check("reset_no_further_go", go_n - base, 1);
      rv = '{iters: 5, a: 32'h1000, b: 32'h2000, abort_sw: 0, pre_abort: 0, len: 6,
             exp_gos: 5, exp_now: 5, exp_res: 32'h2000, exp_ab: 0};
      run_job(rv, 16'h0077);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
